// File: rtl/mult_div.sv
// -----------------------------------------------------------------------------
// mult_div
//
// Iterative multiply/divide unit fed from the register file read ports.
// Executes MULTU, MULT, DIVU and DIV on a WIDTH-bit operand pair, one radix-2
// step per clock, and leaves the result in the HI/LO registers for write-back.
//
// Ports:
//   clk      clock, all state updates on the rising edge
//   reset    asynchronous active-high reset, clears all state
//   Start    operation request, sampled only while Busy=0
//   Op       00 MULTU, 01 MULT, 10 DIVU, 11 DIV (sampled with Start)
//   A        multiplicand / dividend
//   B        multiplier / divisor
//   Busy     high while an accepted operation is in progress
//   Done     one-cycle registered pulse, HI/LO/DivZero valid from this cycle
//   HI       product high word / remainder
//   LO       product low word / quotient
//   DivZero  last completed divide had a zero divisor
// -----------------------------------------------------------------------------
module mult_div #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Start,
    input  logic [1:0]       Op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO,
    output logic             DivZero
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t               state, state_nxt;
    logic [1:0]           op_q;
    logic                 sign_a, sign_b;
    logic [WIDTH-1:0]     a_mag, b_mag;
    logic [CNT_W-1:0]     cnt;
    // Multiply: {partial product high, multiplier being shifted out}.
    // Divide:   {partial remainder, dividend shifting out / quotient shifting in}.
    logic [2*WIDTH-1:0]   acc;

    // Two's complement sign fix-up helpers.
    function automatic logic [WIDTH-1:0] fix_sign_w(input logic [WIDTH-1:0] v,
                                                    input logic neg);
        return neg ? -v : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] fix_sign_2w(input logic [2*WIDTH-1:0] v,
                                                       input logic neg);
        return neg ? -v : v;
    endfunction

    logic signed [WIDTH-1:0] a_s, b_s;
    logic                    signed_op, neg_a, neg_b;
    logic [WIDTH:0]          mul_sum;
    logic [WIDTH:0]          rem_sh, rem_diff;
    logic [2*WIDTH-1:0]      mul_next, div_next, prod_fix;
    logic                    div_zero;

    always_comb begin
        a_s       = $signed(A);
        b_s       = $signed(B);
        signed_op = Op[0];
        neg_a     = signed_op && (a_s < 0);
        neg_b     = signed_op && (b_s < 0);

        // Shift-add: add the multiplicand when the current multiplier bit is set,
        // then shift the 33-bit sum back into the top of the accumulator.
        mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, a_mag} : '0);
        mul_next = {mul_sum, acc[WIDTH-1:1]};

        // Restoring divide: trial-subtract the divisor from the shifted remainder;
        // a borrow means keep the old remainder and shift in a 0 quotient bit.
        rem_sh   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        rem_diff = rem_sh - {1'b0, b_mag};
        div_next = rem_diff[WIDTH] ? {rem_sh[WIDTH-1:0],   acc[WIDTH-2:0], 1'b0}
                                   : {rem_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};

        prod_fix = fix_sign_2w(acc, sign_a ^ sign_b);
        div_zero = (b_mag == '0);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (Start) state_nxt = RUN;
            RUN:     if (cnt == CNT_W'(WIDTH - 1)) state_nxt = FINISH;
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign Busy = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            op_q    <= '0;
            sign_a  <= 1'b0;
            sign_b  <= 1'b0;
            a_mag   <= '0;
            b_mag   <= '0;
            cnt     <= '0;
            acc     <= '0;
            Done    <= 1'b0;
            HI      <= '0;
            LO      <= '0;
            DivZero <= 1'b0;
        end else begin
            state <= state_nxt;
            Done  <= 1'b0;
            case (state)
                // Accept: capture magnitudes and signs so A/B may change afterwards.
                IDLE: begin
                    if (Start) begin
                        op_q   <= Op;
                        sign_a <= neg_a;
                        sign_b <= neg_b;
                        a_mag  <= fix_sign_w(A, neg_a);
                        b_mag  <= fix_sign_w(B, neg_b);
                        cnt    <= '0;
                        acc    <= Op[1] ? {{WIDTH{1'b0}}, fix_sign_w(A, neg_a)}
                                        : {{WIDTH{1'b0}}, fix_sign_w(B, neg_b)};
                    end
                end
                // Iterate: one radix-2 step per cycle.
                RUN: begin
                    cnt <= cnt + 1'b1;
                    acc <= op_q[1] ? div_next : mul_next;
                end
                // Finish: sign fix-up and result write.
                FINISH: begin
                    Done <= 1'b1;
                    if (op_q[1]) begin
                        if (div_zero) begin
                            LO      <= '1;
                            HI      <= fix_sign_w(a_mag, sign_a);
                            DivZero <= 1'b1;
                        end else begin
                            LO      <= fix_sign_w(acc[WIDTH-1:0], sign_a ^ sign_b);
                            // Remainder follows the sign of the dividend.
                            HI      <= fix_sign_w(acc[2*WIDTH-1:WIDTH], sign_a);
                            DivZero <= 1'b0;
                        end
                    end else begin
                        LO      <= prod_fix[WIDTH-1:0];
                        HI      <= prod_fix[2*WIDTH-1:WIDTH];
                        DivZero <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div.sv
// -----------------------------------------------------------------------------
// tb_mult_div
//
// Directed self-checking bench for mult_div: reset state, MULTU/MULT/DIVU/DIV
// results, latency and Busy duration, back-to-back start in the Done cycle,
// divide by zero, ignored Start while busy, and asynchronous reset mid-run.
// -----------------------------------------------------------------------------
module tb_mult_div;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         Start;
    logic [1:0]   Op;
    logic [W-1:0] A, B;
    logic         Busy, Done, DivZero;
    logic [W-1:0] HI, LO;

    int checks = 0;
    int fails  = 0;

    mult_div #(.WIDTH(W)) dut (
        .clk     (clk),
        .reset   (reset),
        .Start   (Start),
        .Op      (Op),
        .A       (A),
        .B       (B),
        .Busy    (Busy),
        .Done    (Done),
        .HI      (HI),
        .LO      (LO),
        .DivZero (DivZero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive a request now; the next rising edge is edge 0. Returns #1 after it.
    task automatic start_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        Start = 1'b1;
        Op    = op;
        A     = a;
        B     = b;
        @(posedge clk);
        #1;
        Start = 1'b0;
        A     = $urandom;
        B     = $urandom;
        Op    = 2'($urandom_range(3));
    endtask

    // Wait (bounded) for Done; lat = edges after edge 0, 0 on timeout.
    task automatic wait_done(input int maxc, output int lat, output int busy_cnt);
        lat      = 0;
        busy_cnt = Busy ? 1 : 0;
        for (int i = 1; i <= maxc; i++) begin
            @(posedge clk);
            #1;
            if (Done) begin
                lat = i;
                break;
            end
            if (Busy) busy_cnt++;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    int lat, bcnt, done_cnt, done_at;

    initial begin
        reset = 1'b1;
        Start = 1'b0;
        Op    = 2'b00;
        A     = '0;
        B     = '0;
        idle(2);
        check("rst_busy", 64'(Busy), 64'd0);
        check("rst_done", 64'(Done), 64'd0);
        check("rst_hilo", {HI, LO}, 64'd0);
        check("rst_dz",   64'(DivZero), 64'd0);
        #2 reset = 1'b0;
        idle(2);

        // MULTU max * max
        start_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("multu_busy_e0", 64'(Busy), 64'd1);
        check("multu_done_e0", 64'(Done), 64'd0);
        wait_done(40, lat, bcnt);
        check("multu_lat",  64'(lat),  64'd33);
        check("multu_busy_cycles", 64'(bcnt), 64'd33);
        check("multu_busy_at_done", 64'(Busy), 64'd0);
        check("multu_hilo", {HI, LO}, 64'hFFFF_FFFE_0000_0001);
        check("multu_dz",   64'(DivZero), 64'd0);
        idle(1);
        check("multu_done_pulse", 64'(Done), 64'd0);
        idle(2);

        // MULT -3 * 7, then DIVU 100/7 started in the Done cycle
        start_op(2'b01, 32'hFFFF_FFFD, 32'd7);
        wait_done(40, lat, bcnt);
        check("mult_lat",  64'(lat), 64'd33);
        check("mult_hilo", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFEB);
        start_op(2'b10, 32'd100, 32'd7);
        check("b2b_accept", 64'(Busy), 64'd1);
        wait_done(40, lat, bcnt);
        check("divu_lat",  64'(lat), 64'd33);
        check("divu_hilo", {HI, LO}, {32'd2, 32'd14});
        idle(2);

        // DIV -7 / 2, then most-negative / -1
        start_op(2'b11, 32'hFFFF_FFF9, 32'd2);
        wait_done(40, lat, bcnt);
        check("div_neg_hilo", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFFD);
        idle(1);
        start_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(40, lat, bcnt);
        check("div_ovf_hilo", {HI, LO}, 64'h0000_0000_8000_0000);
        check("div_ovf_dz",   64'(DivZero), 64'd0);
        idle(1);

        // DIVU by zero, then a multiply clears DivZero
        start_op(2'b10, 32'h1234_5678, 32'd0);
        wait_done(40, lat, bcnt);
        check("dz_lat",  64'(lat), 64'd33);
        check("dz_hilo", {HI, LO}, 64'h1234_5678_FFFF_FFFF);
        check("dz_flag", 64'(DivZero), 64'd1);
        idle(1);
        start_op(2'b00, 32'd2, 32'd3);
        wait_done(40, lat, bcnt);
        check("after_dz_hilo", {HI, LO}, 64'd6);
        check("after_dz_flag", 64'(DivZero), 64'd0);
        idle(1);

        // Start pulses while busy are ignored
        start_op(2'b00, 32'd5, 32'd5);
        done_cnt = 0;
        done_at  = 0;
        for (int i = 1; i <= 40; i++) begin
            Start = (i == 5) || (i == 20);
            Op    = (i == 5) ? 2'b11 : 2'b01;
            A     = (i == 5) ? 32'd1000 : 32'hFFFF_FFF0;
            B     = (i == 5) ? 32'd3    : 32'd9;
            @(posedge clk);
            #1;
            if (Done) begin
                done_cnt++;
                done_at = i;
            end
        end
        Start = 1'b0;
        check("ign_done_cnt", 64'(done_cnt), 64'd1);
        check("ign_done_at",  64'(done_at),  64'd33);
        check("ign_hilo",     {HI, LO},      64'd25);
        check("ign_busy",     64'(Busy),     64'd0);

        // Asynchronous reset in the middle of a DIVU
        start_op(2'b10, 32'd9, 32'd3);
        idle(10);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_busy", 64'(Busy), 64'd0);
        check("mid_rst_done", 64'(Done), 64'd0);
        check("mid_rst_hilo", {HI, LO}, 64'd0);
        check("mid_rst_dz",   64'(DivZero), 64'd0);
        idle(2);
        reset = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (Done) done_cnt++;
        end
        check("mid_rst_no_done", 64'(done_cnt), 64'd0);
        start_op(2'b10, 32'd9, 32'd3);
        wait_done(40, lat, bcnt);
        check("post_rst_lat",  64'(lat), 64'd33);
        check("post_rst_hilo", {HI, LO}, 64'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
